// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters with registered sync, blank and frame outputs.
// Optional macro SYNC_DELAY_EN adds a 2-cycle pipeline on hsync/vsync/blank only.
module vga_timing #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29
) (
  input  logic        pixel_clk,
  input  logic        reset,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        frame_start,
  output logic [7:0]  frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS_END    = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS_END    = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_next;
  logic [9:0]  v_next;
  logic        h_wrap;
  logic        hsync_d, vsync_d, blank_d, frame_start_d;
  logic        hsync_r, vsync_r, blank_r;

  // Decode from the next counts so the registered flags line up with the registered counts.
  always_comb begin
    h_wrap = (hcount == H_LAST);
    h_next = h_wrap ? 11'd0 : hcount + 11'd1;
    v_next = vcount;
    if (h_wrap)
      v_next = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;

    hsync_d       = !((h_next >= H_SYNC_START) && (h_next < H_SYNC_END));
    vsync_d       = !((v_next >= V_SYNC_START) && (v_next < V_SYNC_END));
    blank_d       = (h_next >= H_VIS_END) || (v_next >= V_VIS_END);
    frame_start_d = (h_next == 11'd0) && (v_next == 10'd0);
  end

  // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      hcount      <= 11'd0;
      vcount      <= 10'd0;
      hsync_r     <= 1'b1;
      vsync_r     <= 1'b1;
      blank_r     <= 1'b0;
      frame_start <= 1'b1;
      frame_count <= 8'd0;
    end else begin
      hcount      <= h_next;
      vcount      <= v_next;
      hsync_r     <= hsync_d;
      vsync_r     <= vsync_d;
      blank_r     <= blank_d;
      frame_start <= frame_start_d;
      if (frame_start_d)
        frame_count <= frame_count + 8'd1;
    end
  end

`ifdef SYNC_DELAY_EN
  // Two extra stages match the downstream sprite pipeline latency.
  logic [1:0] hsync_pipe, vsync_pipe, blank_pipe;

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      hsync_pipe <= 2'b11;
      vsync_pipe <= 2'b11;
      blank_pipe <= 2'b00;
    end else begin
      hsync_pipe <= {hsync_pipe[0], hsync_r};
      vsync_pipe <= {vsync_pipe[0], vsync_r};
      blank_pipe <= {blank_pipe[0], blank_r};
    end
  end

  assign hsync = hsync_pipe[1];
  assign vsync = vsync_pipe[1];
  assign blank = blank_pipe[1];
`else
  assign hsync = hsync_r;
  assign vsync = vsync_r;
  assign blank = blank_r;
`endif

endmodule
